// File: rtl/square_wave_channel_pkg.sv
// square_wave_channel_pkg: shared constants, duty encoding and duty lookup for the square channels.
package square_wave_channel_pkg;
    localparam int FREQ_W = 11;
    localparam int LEN_MAX = 64;
    localparam int VOL_W = 4;
    typedef enum logic [1:0] {
        DUTY_12 = 2'b00,
        DUTY_25 = 2'b01,
        DUTY_50 = 2'b10,
        DUTY_75 = 2'b11
    } duty_t;
    // Bit n is the waveform level at duty step n.
    localparam logic [7:0] DUTY_TABLE [4] = '{8'b1000_0000, 8'b1000_0001, 8'b1110_0001, 8'b0111_1110};
    function automatic logic duty_bit(duty_t duty, logic [2:0] pos);
        return DUTY_TABLE[duty][pos];
    endfunction
endpackage

// File: rtl/square_wave_channel_if.sv
// square_wave_channel_if: register/strobe inputs and mixer/status outputs of one square channel.
interface square_wave_channel_if;
    import square_wave_channel_pkg::*;
    logic             freq_tick;
    logic             len_tick;
    logic [7:0]       freq_lo;
    logic [7:0]       freq_hi;
    logic [7:0]       nr11;
    logic             length_load;
    logic             length_en;
    logic             trigger;
    logic             dac_en;
    logic             sweep_ok;
    logic [VOL_W-1:0] volume;
    logic [VOL_W-1:0] sample;
    logic             channel_on;
    modport master (
        output freq_tick, len_tick, freq_lo, freq_hi, nr11, length_load, length_en,
               trigger, dac_en, sweep_ok, volume,
        input  sample, channel_on
    );
    modport slave (
        input  freq_tick, len_tick, freq_lo, freq_hi, nr11, length_load, length_en,
               trigger, dac_en, sweep_ok, volume,
        output sample, channel_on
    );
endinterface

// File: rtl/square_wave_channel_length.sv
// sound_length_counter: length counter with load/trigger/tick handling and a one-cycle expiry pulse.
module sound_length_counter #(
    parameter int LEN_MAX = 64,
    parameter int DATA_W = 6,
    parameter int CNT_W = $clog2(LEN_MAX + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              trigger,
    input  logic              tick,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic              expired
);
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] loaded;
    logic             step;
    // A load in the same cycle as a trigger is applied before the zero check.
    assign loaded = load ? CNT_W'(LEN_MAX) - CNT_W'(data) : count;
    assign step = !trigger && !load && tick && enable && count != '0;
    assign expired = step && count == CNT_W'(1);
    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (trigger)
            count <= loaded == '0 ? CNT_W'(LEN_MAX) : loaded;
        else if (load)
            count <= loaded;
        else if (step)
            count <= count - CNT_W'(1);
    end
endmodule

// File: rtl/square_wave_channel.sv
// square_wave_channel: square tone generator with frequency timer, duty sequencer, length and enable.
module square_wave_channel
    import square_wave_channel_pkg::*;
(
    input logic                  clock,
    input logic                  reset,
    square_wave_channel_if.slave bus
);
    logic [11:0]      freq_timer;
    logic [11:0]      period;
    logic [2:0]       duty_pos;
    logic             channel_on_q;
    logic [VOL_W-1:0] sample_q;
    logic             len_expired;
    logic             kill;
    logic             unused_freq_hi;
    assign unused_freq_hi = ^bus.freq_hi[7:3];
    assign period = 12'd2048 - {1'b0, bus.freq_hi[2:0], bus.freq_lo};
    assign kill = !bus.dac_en || !bus.sweep_ok;
    assign bus.sample = sample_q;
    assign bus.channel_on = channel_on_q;
    sound_length_counter #(.LEN_MAX(LEN_MAX), .DATA_W(6)) u_len (
        .clock   (clock),
        .reset   (reset),
        .load    (bus.length_load),
        .trigger (bus.trigger),
        .tick    (bus.len_tick),
        .enable  (bus.length_en),
        .data    (bus.nr11[5:0]),
        .expired (len_expired)
    );
    // Frequency is only sampled on reload, so sweep writes land at the next period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            freq_timer <= '0;
            duty_pos <= '0;
            channel_on_q <= 1'b0;
            sample_q <= '0;
        end else begin
            sample_q <= (channel_on_q && duty_bit(duty_t'(bus.nr11[7:6]), duty_pos)) ? bus.volume : '0;
            if (bus.trigger)
                freq_timer <= period;
            else if (bus.freq_tick && freq_timer <= 12'd1) begin
                freq_timer <= period;
                duty_pos <= duty_pos + 3'd1;
            end else if (bus.freq_tick)
                freq_timer <= freq_timer - 12'd1;
            channel_on_q <= kill ? 1'b0 : bus.trigger ? 1'b1 : len_expired ? 1'b0 : channel_on_q;
        end
    end
endmodule
